spi_av_cmd_queue: RTL and testbench

Avalon-MM slave front end for the SpeedSPI controller: the next generation of the SPI register writer, generalised to `CHANNELS` independent SPI channels, with a command FIFO and a valid/ready handshake toward the SPI engine. CPU writes become per-channel control pulses, per-channel speed settings, or queued commands. A readable status/speed space lets software poll queue state instead of pacing writes blindly. Sits between the Avalon interconnect and the SPI engine.

---
 rtl/spi_av_cmd_queue.sv | 216 +++++++++++++++++++++
 tb/tb_spi_av_cmd_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_av_cmd_queue.sv
// spi_av_cmd_queue
// Avalon-MM slave front end for the SpeedSPI controller. CPU writes become
// per-channel control pulses, per-channel speed codes, or entries in a
// command FIFO that is drained by the SPI engine over a valid/ready handshake.
// A readable SPEED/STATUS space lets software poll queue state.
module spi_av_cmd_queue #(
  parameter int         CHANNELS   = 2,
  parameter int         FIFO_DEPTH = 8,
  parameter int         ADDR_W     = 16,
  parameter logic [1:0] SPEED_RST  = 2'd1,
  parameter int         CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  avs_s0_write,
  input  logic                  avs_s0_read,
  input  logic [ADDR_W-1:0]     avs_s0_address,
  input  logic [31:0]           avs_s0_writedata,
  output logic [31:0]           avs_s0_readdata,
  output logic                  close,
  output logic                  init_c,
  output logic                  init_p,
  output logic [CH_W-1:0]       pulse_ch,
  output logic [31:0]           init_len,
  output logic                  com_valid,
  input  logic                  com_ready,
  output logic [7:0]            com_cmd,
  output logic [23:0]           com_arg,
  output logic [CH_W-1:0]       com_ch,
  output logic [2*CHANNELS-1:0] speed
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 32 + CH_W;
  localparam int UPPER_W = ADDR_W - 3 - CH_W;

  localparam logic [2:0] REG_COMMAND = 3'd1;
  localparam logic [2:0] REG_CLOSE   = 3'd3;
  localparam logic [2:0] REG_INIT    = 3'd4;
  localparam logic [2:0] REG_OPEN    = 3'd5;
  localparam logic [2:0] REG_SPEED   = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Registers
  logic [31:0]           r_readdata;
  logic                  r_close;
  logic                  r_init_c;
  logic                  r_init_p;
  logic [CH_W-1:0]       r_pulse_ch;
  logic [31:0]           r_init_len;
  logic [2*CHANNELS-1:0] r_speed;
  logic                  r_overflow;
  logic [LVL_W-1:0]      r_level;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];

  // Address decode
  logic [2:0]       w_reg;
  logic [CH_W-1:0]  w_ch;
  logic             w_upper_zero;
  logic             w_ch_ok;
  logic             w_hit;
  logic             w_wr_hit;
  logic             w_wr_cmd;
  logic             w_wr_close;
  logic             w_wr_init;
  logic             w_wr_open;
  logic             w_wr_speed;
  logic             w_wr_status;

  assign w_reg        = avs_s0_address[2:0];
  assign w_ch         = avs_s0_address[3 +: CH_W];
  assign w_upper_zero = (avs_s0_address[ADDR_W-1 -: UPPER_W] == {UPPER_W{1'b0}});
  assign w_ch_ok      = (32'(w_ch) < 32'(CHANNELS));
  assign w_hit        = w_upper_zero && w_ch_ok;
  assign w_wr_hit     = avs_s0_write && w_hit;
  assign w_wr_cmd     = w_wr_hit && (w_reg == REG_COMMAND);
  assign w_wr_close   = w_wr_hit && (w_reg == REG_CLOSE);
  assign w_wr_init    = w_wr_hit && (w_reg == REG_INIT);
  assign w_wr_open    = w_wr_hit && (w_reg == REG_OPEN);
  assign w_wr_speed   = w_wr_hit && (w_reg == REG_SPEED);
  assign w_wr_status  = w_wr_hit && (w_reg == REG_STATUS);

  // FIFO control: a push into a full FIFO is accepted only when the head
  // leaves in the same cycle; otherwise it is dropped and flagged.
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf_set;
  logic               w_ovf_clr;
  logic [ENTRY_W-1:0] w_head;

  assign w_empty   = (r_level == {LVL_W{1'b0}});
  assign w_full    = (r_level == LVL_FULL);
  assign w_pop     = !w_empty && com_ready;
  assign w_push    = w_wr_cmd && (!w_full || w_pop);
  assign w_ovf_set = w_wr_cmd && w_full && !w_pop;
  assign w_ovf_clr = w_wr_status && avs_s0_writedata[18];
  assign w_head    = r_mem[r_rd_ptr];

  // Read data selection
  logic [1:0]  w_speed_sel;
  logic [15:0] w_level16;
  logic [31:0] w_rdata;

  assign w_speed_sel = r_speed[{w_ch, 1'b0} +: 2];
  assign w_level16   = 16'(r_level);

  // Select the read value from pre-update state for the addressed register
  always_comb begin
    w_rdata = 32'd0;
    if (w_hit) begin
      case (w_reg)
        REG_SPEED:  w_rdata = {30'd0, w_speed_sel};
        REG_STATUS: w_rdata = {13'd0, r_overflow, w_full, w_empty, w_level16};
        default:    w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  // Capture read data on a read strobe; hold it until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_readdata <= 32'd0;
    end else if (avs_s0_read) begin
      r_readdata <= w_rdata;
    end
  end

  // One-cycle control pulses with their channel and open length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_close    <= 1'b0;
      r_init_c   <= 1'b0;
      r_init_p   <= 1'b0;
      r_pulse_ch <= {CH_W{1'b0}};
      r_init_len <= 32'd0;
    end else begin
      r_close    <= w_wr_close;
      r_init_c   <= w_wr_init;
      r_init_p   <= w_wr_open;
      r_pulse_ch <= (w_wr_close || w_wr_init || w_wr_open) ? w_ch : {CH_W{1'b0}};
      r_init_len <= w_wr_open ? avs_s0_writedata : 32'd0;
    end
  end

  // Per-channel speed codes, held until rewritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed <= {CHANNELS{SPEED_RST}};
    end else if (w_wr_speed) begin
      r_speed[{w_ch, 1'b0} +: 2] <= avs_s0_writedata[1:0];
    end
  end

  // Sticky overflow flag; a new overflow beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // FIFO pointers and fill level; reset empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage; contents are qualified by the level, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_ch, avs_s0_writedata};
    end
  end

  assign avs_s0_readdata = r_readdata;
  assign close           = r_close;
  assign init_c          = r_init_c;
  assign init_p          = r_init_p;
  assign pulse_ch        = r_pulse_ch;
  assign init_len        = r_init_len;
  assign speed           = r_speed;
  assign com_valid       = !w_empty;
  assign com_cmd         = w_head[31:24];
  assign com_arg         = w_head[23:0];
  assign com_ch          = w_head[32 +: CH_W];

endmodule

// File: tb/tb_spi_av_cmd_queue.sv
// Testbench for spi_av_cmd_queue: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
module tb_spi_av_cmd_queue;

  localparam int CHANNELS   = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 16;
  localparam int CH_W       = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_s = 1'b0;
  logic              rd_s = 1'b0;
  logic [ADDR_W-1:0] addr_s = '0;
  logic [31:0]       wdata_s = '0;
  logic [31:0]       rdata_s;
  logic              close_s, init_c_s, init_p_s;
  logic [CH_W-1:0]   pulse_ch_s;
  logic [31:0]       init_len_s;
  logic              com_valid_s;
  logic              com_ready_s = 1'b0;
  logic [7:0]        com_cmd_s;
  logic [23:0]       com_arg_s;
  logic [CH_W-1:0]   com_ch_s;
  logic [2*CHANNELS-1:0] speed_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_av_cmd_queue #(
    .CHANNELS(CHANNELS), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .SPEED_RST(2'd1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .avs_s0_write(wr_s), .avs_s0_read(rd_s), .avs_s0_address(addr_s),
    .avs_s0_writedata(wdata_s), .avs_s0_readdata(rdata_s),
    .close(close_s), .init_c(init_c_s), .init_p(init_p_s), .pulse_ch(pulse_ch_s),
    .init_len(init_len_s), .com_valid(com_valid_s), .com_ready(com_ready_s),
    .com_cmd(com_cmd_s), .com_arg(com_arg_s), .com_ch(com_ch_s), .speed(speed_s)
  );

  typedef struct {
    logic        wr, rd, rdy;
    logic [15:0] addr;
    logic [31:0] data;
    logic        e_close, e_initc, e_initp;
    logic [31:0] e_pch;
    logic [31:0] e_len;
    logic        e_valid;
    logic [3:0]  e_spd;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mkv(input logic wr, input logic rd, input logic rdy,
                               input logic [15:0] addr, input logic [31:0] data,
                               input logic ec, input logic ei, input logic ep,
                               input logic [31:0] pch, input logic [31:0] len,
                               input logic ev, input logic [3:0] spd,
                               input logic [31:0] erd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.rdy = rdy; v.addr = addr; v.data = data;
    v.e_close = ec; v.e_initc = ei; v.e_initp = ep; v.e_pch = pch;
    v.e_len = len; v.e_valid = ev; v.e_spd = spd; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    wr_s = 1'b0; rd_s = 1'b0; addr_s = '0; wdata_s = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    com_ready_s = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic bus_wr(input int rg, input int ch, input logic [31:0] d);
    addr_s = 16'((ch << 3) | rg); wdata_s = d; wr_s = 1'b1;
    tick();
    wr_s = 1'b0;
  endtask

  task automatic bus_rd(input int rg, input int ch, output logic [31:0] q);
    addr_s = 16'((ch << 3) | rg); rd_s = 1'b1;
    tick();
    rd_s = 1'b0;
    tick();
    q = rdata_s;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] c, input logic [23:0] a, input logic [0:0] ch);
    chk({tag, "_valid"}, 32'(com_valid_s), 32'd1);
    chk({tag, "_cmd"},   32'(com_cmd_s),   32'(c));
    chk({tag, "_arg"},   32'(com_arg_s),   32'(a));
    chk({tag, "_ch"},    32'(com_ch_s),    32'(ch));
  endtask

  vec_t        vecs[21];
  logic [32:0] q[$];
  logic [1:0]  m_spd[2];
  logic        m_ovf;
  logic [31:0] m_rd;
  logic [31:0] rv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk("rst_valid", 32'(com_valid_s), 32'd0);
    chk("rst_close", 32'(close_s), 32'd0);
    chk("rst_initc", 32'(init_c_s), 32'd0);
    chk("rst_initp", 32'(init_p_s), 32'd0);
    chk("rst_pch", 32'(pulse_ch_s), 32'd0);
    chk("rst_len", init_len_s, 32'd0);
    chk("rst_speed", 32'(speed_s), 32'h5);
    chk("rst_rdata", rdata_s, 32'd0);
    bus_rd(7, 0, rv);
    chk("rst_status", rv, 32'h0001_0000);

    // ---------------- reset mid-burst ----------------
    bus_wr(6, 0, 32'd2);
    chk("mb_speed_pre", 32'(speed_s), 32'h6);
    bus_wr(1, 0, 32'h0100_0001);
    bus_wr(1, 1, 32'h0200_0002);
    addr_s = 16'h0001; wdata_s = 32'h0300_0003; wr_s = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mb_valid_async", 32'(com_valid_s), 32'd0);
    chk("mb_speed_async", 32'(speed_s), 32'h5);
    wr_s = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mb_valid", 32'(com_valid_s), 32'd0);
    bus_rd(7, 0, rv);
    chk("mb_status", rv, 32'h0001_0000);
    chk("mb_speed", 32'(speed_s), 32'h5);

    // ---------------- vector table ----------------
    do_reset();
    vecs[0]  = mkv(1,0,0,16'h000D,32'h0000_0200, 0,0,1,32'd1,32'h200, 0,4'h5,32'h0);
    vecs[1]  = mkv(0,0,0,16'h0000,32'h0,         0,0,0,32'd0,32'h0,   0,4'h5,32'h0);
    vecs[2]  = mkv(1,0,0,16'h0003,32'h0000_FFFF, 1,0,0,32'd0,32'h0,   0,4'h5,32'h0);
    vecs[3]  = mkv(1,0,0,16'h000C,32'h0000_1234, 0,1,0,32'd1,32'h0,   0,4'h5,32'h0);
    vecs[4]  = mkv(1,0,0,16'h000E,32'h3,         0,0,0,32'd0,32'h0,   0,4'hD,32'h0);
    vecs[5]  = mkv(0,1,0,16'h000E,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h3);
    vecs[6]  = mkv(0,1,0,16'h0006,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h1);
    vecs[7]  = mkv(1,0,0,16'h1006,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h1);
    vecs[8]  = mkv(0,1,0,16'h100E,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h0);
    vecs[9]  = mkv(1,0,0,16'h0016,32'h2,         0,0,0,32'd0,32'h0,   0,4'hD,32'h0);
    vecs[10] = mkv(0,1,0,16'h000E,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h3);
    vecs[11] = mkv(0,1,0,16'h0016,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h0);
    vecs[12] = mkv(1,0,0,16'h8005,32'h55,        0,0,0,32'd0,32'h0,   0,4'hD,32'h0);
    vecs[13] = mkv(0,1,0,16'h0006,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h1);
    vecs[14] = mkv(1,0,0,16'h0002,32'hFF,        0,0,0,32'd0,32'h0,   0,4'hD,32'h1);
    vecs[15] = mkv(0,1,0,16'h0002,32'h0,         0,0,0,32'd0,32'h0,   0,4'hD,32'h0);
    vecs[16] = mkv(1,0,0,16'h0001,32'h1100_0001, 0,0,0,32'd0,32'h0,   1,4'hD,32'h0);
    vecs[17] = mkv(0,1,0,16'h0007,32'h0,         0,0,0,32'd0,32'h0,   1,4'hD,32'h1);
    vecs[18] = mkv(1,1,0,16'h000E,32'h2,         0,0,0,32'd0,32'h0,   1,4'h9,32'h3);
    vecs[19] = mkv(0,0,1,16'h0000,32'h0,         0,0,0,32'd0,32'h0,   0,4'h9,32'h3);
    vecs[20] = mkv(0,1,0,16'h0007,32'h0,         0,0,0,32'd0,32'h0,   0,4'h9,32'h0001_0000);
    for (int i = 0; i < 21; i++) begin
      wr_s = vecs[i].wr; rd_s = vecs[i].rd; com_ready_s = vecs[i].rdy;
      addr_s = vecs[i].addr; wdata_s = vecs[i].data;
      tick();
      chk($sformatf("v%0d_close", i), 32'(close_s), 32'(vecs[i].e_close));
      chk($sformatf("v%0d_initc", i), 32'(init_c_s), 32'(vecs[i].e_initc));
      chk($sformatf("v%0d_initp", i), 32'(init_p_s), 32'(vecs[i].e_initp));
      chk($sformatf("v%0d_pch", i), 32'(pulse_ch_s), vecs[i].e_pch);
      chk($sformatf("v%0d_len", i), init_len_s, vecs[i].e_len);
      chk($sformatf("v%0d_valid", i), 32'(com_valid_s), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_speed", i), 32'(speed_s), 32'(vecs[i].e_spd));
      chk($sformatf("v%0d_rdata", i), rdata_s, vecs[i].e_rd);
    end
    idle_bus();
    com_ready_s = 1'b0;

    // ---------------- queue order ----------------
    do_reset();
    bus_wr(1, 0, 32'h1100_0001);
    bus_wr(1, 1, 32'h2200_0002);
    bus_wr(1, 0, 32'h3300_0003);
    chk_head("qo0", 8'h11, 24'h1, 1'b0);
    com_ready_s = 1'b1;
    tick();
    chk_head("qo1", 8'h22, 24'h2, 1'b1);
    tick();
    chk_head("qo2", 8'h33, 24'h3, 1'b0);
    tick();
    chk("qo_empty", 32'(com_valid_s), 32'd0);
    com_ready_s = 1'b0;

    // ---------------- overflow ----------------
    do_reset();
    for (int i = 0; i < 9; i++) bus_wr(1, i % 2, {8'(i + 1), 24'(i)});
    bus_rd(7, 0, rv);
    chk("ov_status", rv, 32'h0006_0008);
    bus_wr(7, 0, 32'h0004_0000);
    bus_rd(7, 0, rv);
    chk("ov_cleared", rv, 32'h0002_0008);
    com_ready_s = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("ov_pop%0d", i), 8'(i + 1), 24'(i), 1'(i % 2));
      tick();
    end
    chk("ov_drained", 32'(com_valid_s), 32'd0);
    com_ready_s = 1'b0;

    // ---------------- full push + pop ----------------
    do_reset();
    for (int i = 0; i < 8; i++) bus_wr(1, i % 2, {8'(i + 1), 24'(i * 3)});
    com_ready_s = 1'b1;
    bus_wr(1, 1, 32'hAA00_0000);
    com_ready_s = 1'b0;
    bus_rd(7, 0, rv);
    chk("fp_status", rv, 32'h0002_0008);
    com_ready_s = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk_head($sformatf("fp_pop%0d", i - 1), 8'(i + 1), 24'(i * 3), 1'(i % 2));
      tick();
    end
    chk_head("fp_pop7", 8'hAA, 24'h0, 1'b1);
    tick();
    chk("fp_drained", 32'(com_valid_s), 32'd0);
    com_ready_s = 1'b0;

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    q.delete();
    m_spd[0] = 2'd1; m_spd[1] = 2'd1; m_ovf = 1'b0; m_rd = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int op, rg, ch;
      bit hit, w, r, rdy, pop, push_req, novf, pul;
      logic [15:0] a;
      logic [31:0] d;
      logic [32:0] hd;
      op = $urandom_range(0, 3);
      w  = (op == 1) || (op == 3);
      r  = (op == 2) || (op == 3);
      rg = $urandom_range(0, 7);
      if (w && ($urandom_range(0, 1) == 1)) rg = 1;
      ch = $urandom_range(0, 1);
      hit = ($urandom_range(0, 7) != 0);
      a = hit ? {12'd0, 1'(ch), 3'(rg)} : {12'($urandom_range(1, 4095)), 1'(ch), 3'(rg)};
      d = $urandom;
      if (((cyc / 200) % 2) == 1) rdy = ($urandom_range(0, 3) == 0);
      else                        rdy = ($urandom_range(0, 3) != 0);
      // expected results from pre-cycle model state
      if (r) begin
        if (hit && rg == 6)      m_rd = {30'd0, m_spd[ch]};
        else if (hit && rg == 7) m_rd = {13'd0, m_ovf, q.size() == FIFO_DEPTH, q.size() == 0, 16'(q.size())};
        else                     m_rd = 32'd0;
      end
      pul      = w && hit && (rg == 3 || rg == 4 || rg == 5);
      pop      = (q.size() > 0) && rdy;
      push_req = w && hit && (rg == 1);
      novf     = push_req && (q.size() == FIFO_DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (push_req && !novf) q.push_back({1'(ch), d});
      if (novf) m_ovf = 1'b1;
      else if (w && hit && rg == 7 && d[18]) m_ovf = 1'b0;
      if (w && hit && rg == 6) m_spd[ch] = d[1:0];
      // drive and step
      wr_s = w; rd_s = r; addr_s = a; wdata_s = d; com_ready_s = rdy;
      tick();
      chk("rnd_close", 32'(close_s), 32'(w && hit && rg == 3));
      chk("rnd_initc", 32'(init_c_s), 32'(w && hit && rg == 4));
      chk("rnd_initp", 32'(init_p_s), 32'(w && hit && rg == 5));
      chk("rnd_pch", 32'(pulse_ch_s), pul ? 32'(ch) : 32'd0);
      chk("rnd_len", init_len_s, (w && hit && rg == 5) ? d : 32'd0);
      chk("rnd_speed", 32'(speed_s), 32'({m_spd[1], m_spd[0]}));
      chk("rnd_rdata", rdata_s, m_rd);
      chk("rnd_valid", 32'(com_valid_s), 32'(q.size() > 0));
      if (q.size() > 0) begin
        hd = q[0];
        chk("rnd_head", {com_cmd_s, com_arg_s}, hd[31:0]);
        chk("rnd_head_ch", 32'(com_ch_s), 32'(hd[32]));
      end
    end
    idle_bus();
    com_ready_s = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
